uart_rx: RTL and testbench

- UART receiver; the receive-side counterpart of the team's uart_tx.
- Recovers 8N1-style asynchronous frames from the serial line `rxd`: 1 start bit (0), `data_bits` data bits sent LSB first, 1 stop bit (1), no parity.
- Uses the same `br` baud-select encoding as uart_tx, so a TX/RX pair with matching parameters interoperates on the same sysclk.
- Presents each received word on a parallel bus with a valid/acknowledge handshake, plus frame-error and overrun flags.

---
 rtl/uart_rx.sv | 113 +++++++++++
 tb/tb_uart_rx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1-style serial receiver with a valid/ack word handshake and frame-error/overrun flags.
// Latency: rxd_doneH pulses about 2 + CPB/2 + (data_bits+1)*CPB sysclk cycles after the start-bit falling edge.
// Backpressure: none on the line; an unacknowledged word is overwritten and overrunH is latched.
module uart_rx #(
   parameter int         data_bits                 = 8,
   parameter int         received_bit_counter_bits = 4,
   parameter logic [2:0] br                        = 3'b000
) (
   input  logic                 sysclk,
   input  logic                 rst_n,
   input  logic                 rxd,
   input  logic                 rd_ackH,
   output logic [data_bits-1:0] rx_data,
   output logic                 rxd_doneH,
   output logic                 rx_validH,
   output logic                 frame_errH,
   output logic                 overrunH,
   output logic                 rx_busyH
);

   localparam int cpb   = (br == 3'b001) ? 117 :
                          (br == 3'b010) ? 58  :
                          (br == 3'b011) ? 39  :
                          (br == 3'b100) ? 19  : 234;
   localparam int cnt_w = $clog2(cpb);
   localparam logic [cnt_w-1:0] half_last = cnt_w'(cpb / 2 - 1);
   localparam logic [cnt_w-1:0] bit_last  = cnt_w'(cpb - 1);
   localparam logic [received_bit_counter_bits-1:0] last_bit =
      received_bit_counter_bits'(data_bits - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                               state, state_n;
   logic                                 rxd_m, rxd_s, rxd_p;
   logic [cnt_w-1:0]                     cnt;
   logic [received_bit_counter_bits-1:0] bit_cnt;
   logic [data_bits-1:0]                 shreg;
   logic                                 fall, half_tick, bit_tick;
   logic                                 take_bit, load_good, load_err;

   assign fall      = rxd_p & ~rxd_s;
   assign half_tick = (cnt == half_last);
   assign bit_tick  = (cnt == bit_last);
   assign rx_busyH  = (state != IDLE);

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // Leaving STOP at mid stop bit leaves half a bit to catch a back-to-back start edge.
   always_comb begin
      state_n   = state;
      take_bit  = 1'b0;
      load_good = 1'b0;
      load_err  = 1'b0;
      case (state)
         IDLE:  if (fall) state_n = START;
         START: if (half_tick) state_n = rxd_s ? IDLE : DATA;
         DATA:  if (bit_tick) begin
                   take_bit = 1'b1;
                   if (bit_cnt == last_bit) state_n = STOP;
                end
         STOP:  if (bit_tick) begin
                   state_n   = IDLE;
                   load_good = rxd_s;
                   load_err  = ~rxd_s;
                end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         rxd_m      <= 1'b1;
         rxd_s      <= 1'b1;
         rxd_p      <= 1'b1;
         cnt        <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         rx_data    <= '0;
         rxd_doneH  <= 1'b0;
         rx_validH  <= 1'b0;
         frame_errH <= 1'b0;
         overrunH   <= 1'b0;
      end else begin
         rxd_m <= rxd;
         rxd_s <= rxd_m;
         rxd_p <= rxd_s;

         if (state_n != state || state == IDLE || bit_tick) cnt <= '0;
         else                                                cnt <= cnt + cnt_w'(1);

         if (state == IDLE)  bit_cnt <= '0;
         else if (take_bit)  bit_cnt <= bit_cnt + received_bit_counter_bits'(1);

         if (take_bit) shreg <= {rxd_s, shreg[data_bits-1:1]};

         rxd_doneH <= load_good;
         // A load in the same cycle as an acknowledge keeps the new word valid.
         if (load_good) begin
            rx_data    <= shreg;
            rx_validH  <= 1'b1;
            frame_errH <= 1'b0;
            if (rx_validH && !rd_ackH) overrunH <= 1'b1;
         end else begin
            if (rd_ackH)  rx_validH  <= 1'b0;
            if (load_err) frame_errH <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one instance at 234 cycles/bit, one at 19 cycles/bit, sharing clock and reset.
module tb_uart_rx;

   logic       sysclk = 1'b0;
   logic       rst_n;
   logic       rxd0, rxd4, ack0, ack4;
   logic [7:0] data0, data4;
   logic       done0, valid0, ferr0, ovr0, busy0;
   logic       done4, valid4, ferr4, ovr4, busy4;

   always #5 sysclk = ~sysclk;

   uart_rx #(.data_bits(8), .received_bit_counter_bits(4), .br(3'b000)) dut0 (
      .sysclk(sysclk), .rst_n(rst_n), .rxd(rxd0), .rd_ackH(ack0),
      .rx_data(data0), .rxd_doneH(done0), .rx_validH(valid0),
      .frame_errH(ferr0), .overrunH(ovr0), .rx_busyH(busy0));

   uart_rx #(.data_bits(8), .received_bit_counter_bits(4), .br(3'b100)) dut4 (
      .sysclk(sysclk), .rst_n(rst_n), .rxd(rxd4), .rd_ackH(ack4),
      .rx_data(data4), .rxd_doneH(done4), .rx_validH(valid4),
      .frame_errH(ferr4), .overrunH(ovr4), .rx_busyH(busy4));

   int cyc = 0;
   int n0 = 0, n4 = 0, t0 = 0, t4 = 0;
   int n_chk = 0, n_fail = 0;
   int t_start;

   always @(posedge sysclk) cyc <= cyc + 1;

   always @(negedge sysclk) begin
      if (done0) begin n0 <= n0 + 1; t0 <= cyc; end
      if (done4) begin n4 <= n4 + 1; t4 <= cyc; end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_range(input string name, input int act, input int lo, input int hi);
      n_chk++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge sysclk);
         #1;
      end
   endtask

   // Serial frame: start 0, 8 data bits LSB first, stop bit as given.
   task automatic send_frame(input bit fast, input logic [7:0] d, input logic stop);
      logic [9:0] bits;
      bits    = {stop, d, 1'b0};
      t_start = cyc;
      for (int i = 0; i < 10; i++) begin
         if (fast) rxd4 = bits[i];
         else      rxd0 = bits[i];
         tick(fast ? 19 : 234);
      end
   endtask

   typedef struct {
      logic [7:0] d;
      logic       stop;
      logic       ack;
      int         gap;
      logic [7:0] e_data;
      logic       e_valid;
      logic       e_ferr;
      logic       e_ovr;
      int         e_done;
   } vec_t;

   vec_t tbl[6];

   // Reference state for the randomized phase, updated from frame-level rules.
   logic [7:0] m_data;
   logic       m_valid, m_ferr, m_ovr;
   logic [7:0] r_d;
   logic       r_stop;
   int         r_gap, n_before, prev_t4;
   logic       prev_b2b;

   initial begin
      tbl[0] = '{8'h3C, 1'b0, 1'b0, 5, 8'h00, 1'b0, 1'b1, 1'b0, 0};
      tbl[1] = '{8'h3C, 1'b1, 1'b1, 0, 8'h3C, 1'b1, 1'b0, 1'b0, 1};
      tbl[2] = '{8'h5A, 1'b1, 1'b0, 0, 8'h5A, 1'b1, 1'b0, 1'b0, 1};
      tbl[3] = '{8'h81, 1'b0, 1'b0, 5, 8'h5A, 1'b1, 1'b1, 1'b0, 0};
      tbl[4] = '{8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b1, 1};
      tbl[5] = '{8'hFF, 1'b1, 1'b1, 5, 8'hFF, 1'b1, 1'b0, 1'b1, 1};

      rst_n = 1'b0; rxd0 = 1'b1; rxd4 = 1'b1; ack0 = 1'b0; ack4 = 1'b0;
      tick(3);
      chk("rst_data0", data0, 0);  chk("rst_done0", done0, 0);
      chk("rst_valid0", valid0, 0); chk("rst_ferr0", ferr0, 0);
      chk("rst_ovr0", ovr0, 0);    chk("rst_busy0", busy0, 0);
      chk("rst_data4", data4, 0);  chk("rst_valid4", valid4, 0);
      chk("rst_busy4", busy4, 0);
      rst_n = 1'b1;
      tick(5);

      // Basic frame at 234 cycles/bit with start-edge-to-done latency.
      send_frame(1'b0, 8'hA5, 1'b1);
      chk("basic_done", n0, 1);
      chk_range("basic_latency", t0 - t_start, 2224, 2226);
      chk("basic_data", data0, 8'hA5);
      chk("basic_valid", valid0, 1);
      chk("basic_ferr", ferr0, 0);
      tick(20);

      // Glitch shorter than half a bit must be ignored.
      rxd0 = 1'b0;
      tick(10);
      chk("glitch_busy", busy0, 1);
      tick(40);
      rxd0 = 1'b1;
      tick(250);
      chk("glitch_idle", busy0, 0);
      chk("glitch_done", n0, 1);
      chk("glitch_data", data0, 8'hA5);
      chk("glitch_valid", valid0, 1);
      chk("glitch_ferr", ferr0, 0);
      chk("glitch_ovr", ovr0, 0);

      // Acknowledge in the exact load cycle: load wins, no overrun.
      fork
         send_frame(1'b0, 8'h3C, 1'b1);
         begin
            tick(2225);
            ack0 = 1'b1;
            tick(1);
            ack0 = 1'b0;
         end
      join
      chk("ackload_done", n0, 2);
      chk("ackload_data", data0, 8'h3C);
      chk("ackload_valid", valid0, 1);
      chk("ackload_ovr", ovr0, 0);
      ack0 = 1'b1;
      tick(1);
      ack0 = 1'b0;
      chk("ack_clear0", valid0, 0);

      // Table of frame sequences on the fast receiver.
      prev_b2b = 1'b0;
      for (int i = 0; i < 6; i++) begin
         n_before = n4;
         prev_t4  = t4;
         send_frame(1'b1, tbl[i].d, tbl[i].stop);
         chk($sformatf("tbl%0d_done", i), n4 - n_before, tbl[i].e_done);
         chk($sformatf("tbl%0d_data", i), data4, tbl[i].e_data);
         chk($sformatf("tbl%0d_valid", i), valid4, tbl[i].e_valid);
         chk($sformatf("tbl%0d_ferr", i), ferr4, tbl[i].e_ferr);
         chk($sformatf("tbl%0d_ovr", i), ovr4, tbl[i].e_ovr);
         if (prev_b2b && tbl[i].stop)
            chk($sformatf("tbl%0d_spacing", i), t4 - prev_t4, 190);
         rxd4 = 1'b1;
         if (tbl[i].ack) begin
            ack4 = 1'b1;
            tick(1);
            ack4 = 1'b0;
            chk($sformatf("tbl%0d_ackclr", i), valid4, 0);
         end
         prev_b2b = tbl[i].stop && !tbl[i].ack && tbl[i].gap == 0;
         tick(tbl[i].gap);
      end

      // Reset during data bit 4 discards the frame and clears everything at once.
      rxd4 = 1'b0;
      tick(19);
      for (int i = 0; i < 4; i++) begin
         rxd4 = i[0];
         tick(19);
      end
      rxd4 = 1'b1;
      tick(9);
      chk("midrst_busy_before", busy4, 1);
      rst_n = 1'b0;
      #2;
      chk("midrst_busy4", busy4, 0);
      chk("midrst_data4", data4, 0);
      chk("midrst_ovr4", ovr4, 0);
      chk("midrst_valid4", valid4, 0);
      chk("midrst_data0", data0, 0);
      tick(3);
      rst_n = 1'b1;
      tick(5);
      n_before = n4;
      send_frame(1'b1, 8'h5A, 1'b1);
      chk("postrst_done", n4 - n_before, 1);
      chk("postrst_data", data4, 8'h5A);
      chk("postrst_valid", valid4, 1);
      chk("postrst_ferr", ferr4, 0);
      chk("postrst_ovr", ovr4, 0);
      tick(3);

      // Randomized frames against the frame-level reference.
      m_data = 8'h5A; m_valid = 1'b1; m_ferr = 1'b0; m_ovr = 1'b0;
      for (int i = 0; i < 25; i++) begin
         r_d    = 8'($urandom_range(0, 255));
         r_stop = ($urandom_range(0, 4) != 0);
         r_gap  = r_stop ? $urandom_range(0, 20) : $urandom_range(3, 20);
         if ($urandom_range(0, 2) == 0) begin
            ack4 = 1'b1;
            tick(1);
            ack4 = 1'b0;
            m_valid = 1'b0;
         end
         n_before = n4;
         send_frame(1'b1, r_d, r_stop);
         if (r_stop) begin
            m_ovr   = m_ovr | m_valid;
            m_data  = r_d;
            m_valid = 1'b1;
            m_ferr  = 1'b0;
         end else begin
            m_ferr  = 1'b1;
         end
         chk($sformatf("rand%0d_done", i), n4 - n_before, r_stop ? 1 : 0);
         chk($sformatf("rand%0d_data", i), data4, m_data);
         chk($sformatf("rand%0d_valid", i), valid4, m_valid);
         chk($sformatf("rand%0d_ferr", i), ferr4, m_ferr);
         chk($sformatf("rand%0d_ovr", i), ovr4, m_ovr);
         rxd4 = 1'b1;
         tick(r_gap);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
